// File: rtl/sar_controller.sv
// Successive-approximation search controller: drives trial words to an external
// combinational comparator and converges on the unknown value one bit per cycle.
module sar_controller #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Greater,
  input  logic             Equal,
  input  logic             Less,
  output logic [WIDTH-1:0] B,
  output logic             En,
  output logic [WIDTH-1:0] Result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, TRIAL, DONE, ERR} state_t;

  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             decided;
  logic             finish;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    busy_d   = 1'b0;
    en_d     = 1'b0;
    decided  = 1'b0;
    finish   = 1'b0;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          acc_d   = '0;
          mask_d  = MSB;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          state_d = TRIAL;
        end
      end
      TRIAL: begin
        // Anything other than exactly one flag means the comparator is not trustworthy.
        case ({Greater, Equal, Less})
          3'b010: begin
            acc_d   = acc_q | mask_q;
            decided = 1'b1;
            finish  = 1'b1;
          end
          3'b100: begin
            acc_d   = acc_q | mask_q;
            decided = 1'b1;
            finish  = mask_q[0];
          end
          3'b001: begin
            decided = 1'b1;
            finish  = mask_q[0];
          end
          default: begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        endcase

        if (decided) begin
          if (finish) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = acc_d;
          end else begin
            mask_d = mask_q >> 1;
            busy_d = 1'b1;
            en_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
    end
  end

  // Trial word is presented only while searching so the comparator sees zero otherwise.
  assign B      = (state_q == TRIAL) ? (acc_q | mask_q) : '0;
  assign En     = en_q;
  assign Result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the trial word and result.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new conversion.
REQ-005 SHALL have ports Greater, Equal and Less, inputs, 1 bit each: comparator flags for unknown A vs trial B.
REQ-006 SHALL have port B, output, WIDTH bits: trial word driven to the comparator.
REQ-007 SHALL have port En, output, 1 bit: comparator enable.
REQ-008 SHALL have port Result, output, WIDTH bits: converged value of A.
REQ-009 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1 bit: sticky flag-protocol error.

Function
REQ-012 SHALL implement an FSM with states IDLE, TRIAL, DONE and ERR.
REQ-013 SHALL hold an internal accumulator acc and a one-hot mask, both WIDTH bits.
REQ-014 In IDLE or ERR, start=1 SHALL load acc=0 and mask=MSB, clear err, and enter TRIAL on the next cycle.
REQ-015 In TRIAL, B SHALL equal acc|mask (combinational from registers), and En and busy SHALL be 1.
REQ-016 Outside TRIAL, B SHALL be 0 and En SHALL be 0.
REQ-017 At each TRIAL clock edge, the flags SHALL be sampled in the same cycle as B (the comparator is combinational).
REQ-018 In TRIAL, if the flags are not exactly one-hot (000, or two or more set), the FSM SHALL go to ERR, leave acc unchanged and set err.
REQ-019 On Equal=1, the FSM SHALL set acc|=mask and go to DONE (early termination).
REQ-020 On Greater=1, the FSM SHALL set acc|=mask; on Less=1, acc SHALL be left unchanged.
REQ-021 After a Greater or Less decision, if mask==1 the FSM SHALL go to DONE; otherwise mask SHALL shift right by 1 and the FSM SHALL stay in TRIAL.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, Result SHALL be loaded from acc, busy SHALL be 0, and the FSM SHALL return to IDLE.
REQ-023 Result SHALL hold its value until the next DONE or reset; ERR SHALL NOT modify Result.
REQ-024 start while in TRIAL or DONE SHALL be ignored, with no restart and no queuing.
REQ-025 err SHALL stay at 1 in ERR until start or reset; start in ERR SHALL begin a new conversion per REQ-014.
REQ-026 Latency, with the start edge as cycle 0, SHALL be:
  - TRIAL at cycles 1..WIDTH;
  - done at cycle WIDTH+1 for a full search;
  - done at cycle k+1 on Equal at trial k.
REQ-027 Result SHALL be the unique value consistent with a correct comparator; the design SHALL NOT check consistency across trials.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state to IDLE and set acc=0, mask=0, Result=0, done=0, err=0, busy=0, En=0 and B=0.
REQ-029 Reset SHALL take priority over start and any in-flight TRIAL; a conversion interrupted by reset SHALL produce no done.
REQ-030 The first start after rst_n returns to 1 SHALL be honoured on the next edge.

Verification
REQ-031 The bench SHALL cover A=1001: trials B=1000 (G), 1100 (L), 1010 (L), 1001 (E) -> Result=1001, done at cycle 5.
REQ-032 The bench SHALL cover A=1000: trial B=1000 (E) -> Result=1000, done at cycle 2, En=1 for exactly 1 cycle.
REQ-033 The bench SHALL cover A=0000: trials 1000, 0100, 0010, 0001 all L -> Result=0000, done at cycle 5; and A=1111: G, G, G, E -> Result=1111.
REQ-034 The bench SHALL cover forcing flags=000 (comparator disabled/stuck) at trial 2 -> ERR, err=1 held, no done, Result keeps its prior value; a subsequent start clears err.
REQ-035 The bench SHALL cover rst_n=0 at trial 3 of A=0110 -> all outputs 0 next cycle, no done; a re-start then gives Result=0110.
REQ-036 The bench SHALL cover start pulsed during TRIAL -> ignored, with the trial sequence and done timing unchanged.
